// File: rtl/ddr_init_seq.sv
// DDR4 power-up sequencer: RESET_n/CKE timing, MRS writes MR3,6,5,4,2,1,0, ZQCL, then config_done.
// Each command is held on cmd_valid until cmd_ready; every post-command wait counts from acceptance.
module ddr_init_seq #(
   parameter int unsigned T_RESET  = 200,
   parameter int unsigned T_CKE    = 500,
   parameter int unsigned T_XPR    = 10,
   parameter int unsigned T_MRD    = 8,
   parameter int unsigned T_MOD    = 24,
   parameter int unsigned T_ZQINIT = 1024
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        start,
   input  logic [97:0] mr_table,
   input  logic        cmd_ready,
   output logic        mem_reset_n,
   output logic        cke,
   output logic        cmd_valid,
   output logic [1:0]  cmd_type,
   output logic [2:0]  mr_sel,
   output logic [13:0] mr_addr,
   output logic        busy,
   output logic        config_done
);

   localparam logic [15:0] T_RESET_C  = 16'(T_RESET);
   localparam logic [15:0] T_CKE_C    = 16'(T_CKE);
   localparam logic [15:0] T_XPR_C    = 16'(T_XPR);
   localparam logic [15:0] T_MRD_C    = 16'(T_MRD);
   localparam logic [15:0] T_MOD_C    = 16'(T_MOD);
   localparam logic [15:0] T_ZQINIT_C = 16'(T_ZQINIT);

   localparam logic [1:0]  CMD_DES   = 2'd0;
   localparam logic [1:0]  CMD_MRS   = 2'd1;
   localparam logic [1:0]  CMD_ZQCL  = 2'd2;
   localparam logic [13:0] ZQCL_ADDR = 14'h0400;

   typedef enum logic [3:0] {
      IDLE, RST_HOLD, CKE_WAIT, XPR_WAIT, MRS_ISSUE,
      MRS_WAIT, MOD_WAIT, ZQ_ISSUE, ZQ_WAIT, DONE
   } state_t;

   state_t      state;
   logic [15:0] cnt;
   logic [2:0]  mr_idx;
   logic [2:0]  next_sel;
   logic [13:0] next_addr;
   logic        wait_over;

   function automatic logic [2:0] sel_of(input logic [2:0] idx);
      case (idx)
         3'd0:    return 3'd3;
         3'd1:    return 3'd6;
         3'd2:    return 3'd5;
         3'd3:    return 3'd4;
         3'd4:    return 3'd2;
         3'd5:    return 3'd1;
         default: return 3'd0;
      endcase
   endfunction

   always_comb begin
      next_sel  = sel_of(mr_idx);
      next_addr = '0;
      for (int i = 0; i < 7; i++) begin
         if (next_sel == 3'(i)) next_addr = mr_table[14*i +: 14];
      end
   end

   // Pre-command states load T and last T cycles; post-acceptance waits load T-1 so the
   // next event lands T cycles after the accepting cycle (minimum one idle cycle).
   assign wait_over = (cnt <= 16'd1);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state       <= IDLE;
         cnt         <= '0;
         mr_idx      <= '0;
         mem_reset_n <= 1'b0;
         cke         <= 1'b0;
         cmd_valid   <= 1'b0;
         cmd_type    <= CMD_DES;
         mr_sel      <= '0;
         mr_addr     <= '0;
         busy        <= 1'b0;
         config_done <= 1'b0;
      end else begin
         case (state)
            IDLE, DONE: begin
               if (start) begin
                  state       <= RST_HOLD;
                  cnt         <= T_RESET_C;
                  mr_idx      <= '0;
                  mem_reset_n <= 1'b0;
                  cke         <= 1'b0;
                  busy        <= 1'b1;
                  config_done <= 1'b0;
               end
            end
            RST_HOLD: begin
               if (wait_over) begin
                  state       <= CKE_WAIT;
                  mem_reset_n <= 1'b1;
                  cnt         <= T_CKE_C;
               end else begin
                  cnt <= cnt - 16'd1;
               end
            end
            CKE_WAIT: begin
               if (wait_over) begin
                  state <= XPR_WAIT;
                  cke   <= 1'b1;
                  cnt   <= T_XPR_C;
               end else begin
                  cnt <= cnt - 16'd1;
               end
            end
            XPR_WAIT, MRS_WAIT: begin
               if (wait_over) begin
                  state     <= MRS_ISSUE;
                  cmd_valid <= 1'b1;
                  cmd_type  <= CMD_MRS;
                  mr_sel    <= next_sel;
                  mr_addr   <= next_addr;
               end else begin
                  cnt <= cnt - 16'd1;
               end
            end
            MRS_ISSUE: begin
               if (cmd_ready) begin
                  cmd_valid <= 1'b0;
                  cmd_type  <= CMD_DES;
                  if (mr_idx == 3'd6) begin
                     state <= MOD_WAIT;
                     cnt   <= T_MOD_C - 16'd1;
                  end else begin
                     state  <= MRS_WAIT;
                     mr_idx <= mr_idx + 3'd1;
                     cnt    <= T_MRD_C - 16'd1;
                  end
               end
            end
            MOD_WAIT: begin
               if (wait_over) begin
                  state     <= ZQ_ISSUE;
                  cmd_valid <= 1'b1;
                  cmd_type  <= CMD_ZQCL;
                  mr_sel    <= 3'd0;
                  mr_addr   <= ZQCL_ADDR;
               end else begin
                  cnt <= cnt - 16'd1;
               end
            end
            ZQ_ISSUE: begin
               if (cmd_ready) begin
                  state     <= ZQ_WAIT;
                  cmd_valid <= 1'b0;
                  cmd_type  <= CMD_DES;
                  cnt       <= T_ZQINIT_C - 16'd1;
               end
            end
            ZQ_WAIT: begin
               if (wait_over) begin
                  state       <= DONE;
                  config_done <= 1'b1;
                  busy        <= 1'b0;
               end else begin
                  cnt <= cnt - 16'd1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ddr_init_seq.sv
// Directed bench for ddr_init_seq: expected output events are queued when a run is started
// and popped by a monitor as the sequencer raises RESET_n, CKE, commands and config_done.
module tb_ddr_init_seq;

   localparam int TR = 200, TC = 500, TX = 10, TM = 8, TMOD = 24, TZQ = 1024;
   localparam int EV_RSTN = 0, EV_CKE = 1, EV_CMD = 2, EV_DONE = 3;

   typedef struct {
      int          kind;
      int          cyc;
      logic [1:0]  typ;
      logic [2:0]  sel;
      logic [13:0] addr;
   } ev_t;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        start = 1'b0;
   logic [97:0] mr_table;
   logic        cmd_ready = 1'b1;
   logic        mem_reset_n, cke, cmd_valid, busy, config_done;
   logic [1:0]  cmd_type;
   logic [2:0]  mr_sel;
   logic [13:0] mr_addr;

   int  cyc = 0;
   int  errors = 0;
   int  checks = 0;
   ev_t exp_q[$];
   logic p_rstn = 1'b0, p_cke = 1'b0, p_vld = 1'b0, p_done = 1'b0;

   ddr_init_seq dut (
      .clock       (clock),
      .reset       (reset),
      .start       (start),
      .mr_table    (mr_table),
      .cmd_ready   (cmd_ready),
      .mem_reset_n (mem_reset_n),
      .cke         (cke),
      .cmd_valid   (cmd_valid),
      .cmd_type    (cmd_type),
      .mr_sel      (mr_sel),
      .mr_addr     (mr_addr),
      .busy        (busy),
      .config_done (config_done)
   );

   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic observe(input int kind);
      ev_t e;
      checks++;
      assert (exp_q.size() > 0) else begin
         errors++;
         $error("FAIL unexpected_event: observed kind=%0d at cycle %0d, expected no event", kind, cyc);
      end
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         check("event_kind", 32'(kind), 32'(e.kind));
         check("event_cycle", 32'(cyc), 32'(e.cyc));
         if (kind == EV_CMD) begin
            check("cmd_type", 32'(cmd_type), 32'(e.typ));
            check("mr_sel", 32'(mr_sel), 32'(e.sel));
            check("mr_addr", 32'(mr_addr), 32'(e.addr));
         end
         if (kind == EV_DONE) check("busy_at_done", 32'(busy), 32'd0);
      end
   endtask

   always @(negedge clock) begin
      if (mem_reset_n && !p_rstn)  observe(EV_RSTN);
      if (cke && !p_cke)           observe(EV_CKE);
      if (cmd_valid && !p_vld)     observe(EV_CMD);
      if (config_done && !p_done)  observe(EV_DONE);
      p_rstn = mem_reset_n;
      p_cke  = cke;
      p_vld  = cmd_valid;
      p_done = config_done;
   end

   // Expected event timeline for a run whose start is sampled in cycle s; MR5 accepted 'stall' cycles late.
   task automatic push_run(input int s, input int stall, input int limit);
      ev_t        q[$];
      logic [2:0] order[7];
      int         v, mr0;
      order = '{3'd3, 3'd6, 3'd5, 3'd4, 3'd2, 3'd1, 3'd0};
      q.push_back('{EV_RSTN, s + TR + 1, 2'd0, 3'd0, 14'd0});
      q.push_back('{EV_CKE, s + TR + TC + 1, 2'd0, 3'd0, 14'd0});
      v   = s + TR + TC + 1 + TX;
      mr0 = v;
      for (int i = 0; i < 7; i++) begin
         q.push_back('{EV_CMD, v, 2'd1, order[i], 14'h0100 + 14'(order[i])});
         mr0 = v;
         v   = v + TM + ((i == 2) ? stall : 0);
      end
      q.push_back('{EV_CMD, mr0 + TMOD, 2'd2, 3'd0, 14'h0400});
      q.push_back('{EV_DONE, mr0 + TMOD + TZQ, 2'd0, 3'd0, 14'd0});
      for (int i = 0; i < limit; i++) exp_q.push_back(q[i]);
   endtask

   task automatic set_table();
      for (int n = 0; n < 7; n++) mr_table[14*n +: 14] = 14'h0100 + 14'(n);
   endtask

   task automatic goto_neg(input int k);
      while (cyc < k) @(negedge clock);
   endtask

   task automatic pulse(input int s);
      goto_neg(s);
      start = 1'b1;
      goto_neg(s + 1);
      start = 1'b0;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_mem_reset_n"}, 32'(mem_reset_n), 32'd0);
      check({tag, "_cke"}, 32'(cke), 32'd0);
      check({tag, "_cmd_valid"}, 32'(cmd_valid), 32'd0);
      check({tag, "_cmd_type"}, 32'(cmd_type), 32'd0);
      check({tag, "_mr_sel"}, 32'(mr_sel), 32'd0);
      check({tag, "_mr_addr"}, 32'(mr_addr), 32'd0);
      check({tag, "_busy"}, 32'(busy), 32'd0);
      check({tag, "_config_done"}, 32'(config_done), 32'd0);
   endtask

   task automatic wait_done(input string tag);
      int i = 0;
      while (!config_done && i < 3000) begin
         @(negedge clock);
         i++;
      end
      check({tag, "_done_seen"}, 32'(config_done), 32'd1);
      @(negedge clock);
      check({tag, "_queue_drained"}, 32'(exp_q.size()), 32'd0);
   endtask

   initial begin
      #150000;
      $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int s, v2;
      set_table();
      #1 reset = 1'b1;
      #1 check_all_zero("reset");
      goto_neg(3);
      reset = 1'b0;

      // Run A: defaults, ready tied high, a stray start during CKE_WAIT.
      s = 10;
      push_run(s, 0, 11);
      pulse(s);
      check("a_busy_s1", 32'(busy), 32'd1);
      check("a_rstn_s1", 32'(mem_reset_n), 32'd0);
      goto_neg(s + 300);
      check("a_cke_wait_rstn", 32'(mem_reset_n), 32'd1);
      check("a_cke_wait_cke", 32'(cke), 32'd0);
      pulse(s + 300);
      check("a_start_ignored_busy", 32'(busy), 32'd1);
      wait_done("run_a");
      goto_neg(cyc + 3);
      check("done_hold_config_done", 32'(config_done), 32'd1);
      check("done_hold_cke", 32'(cke), 32'd1);
      check("done_hold_rstn", 32'(mem_reset_n), 32'd1);
      check("done_hold_busy", 32'(busy), 32'd0);

      // Run B: restart from DONE, MR5 stalled 5 cycles while mr_table changes.
      s = cyc + 5;
      push_run(s, 5, 11);
      pulse(s);
      check("b_restart_config_done", 32'(config_done), 32'd0);
      check("b_restart_cke", 32'(cke), 32'd0);
      check("b_restart_rstn", 32'(mem_reset_n), 32'd0);
      check("b_restart_busy", 32'(busy), 32'd1);
      v2 = s + TR + TC + 1 + TX + 2 * TM;
      goto_neg(v2 - 1);
      cmd_ready = 1'b0;
      for (int k = 0; k < 6; k++) begin
         goto_neg(v2 + k);
         check("stall_valid", 32'(cmd_valid), 32'd1);
         check("stall_type", 32'(cmd_type), 32'd1);
         check("stall_sel", 32'(mr_sel), 32'd5);
         check("stall_addr", 32'(mr_addr), 32'h0105);
         if (k < 5) begin
            mr_table[14*5 +: 14] = 14'h2A00 + 14'(k);
            mr_table[14*4 +: 14] = 14'h1500 + 14'(k);
         end else begin
            set_table();
            cmd_ready = 1'b1;
         end
      end
      goto_neg(v2 + 6);
      check("accept_valid_drop", 32'(cmd_valid), 32'd0);
      check("accept_type_des", 32'(cmd_type), 32'd0);
      wait_done("run_b");

      // Run C: asynchronous reset in the MRS_WAIT after MR6.
      s = cyc + 5;
      push_run(s, 0, 4);
      pulse(s);
      goto_neg(s + TR + TC + 1 + TX + TM + 3);
      #2 reset = 1'b1;
      #1 check_all_zero("async_reset");
      check("c_queue_drained", 32'(exp_q.size()), 32'd0);
      @(negedge clock);
      goto_neg(cyc + 3);
      check_all_zero("held_reset");
      reset = 1'b0;

      // Run D: full sequence after the mid-sequence reset.
      s = cyc + 5;
      push_run(s, 0, 11);
      pulse(s);
      check("d_busy_s1", 32'(busy), 32'd1);
      wait_done("run_d");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/ddr_init_seq.md
Name: ddr_init_seq

Overview:
- Power-up and configuration sequencer for the DDR4 controller.
- Sits directly upstream of the command/timing stage: drives memory reset and CKE, issues the seven MRS commands in JEDEC order (MR3, MR6, MR5, MR4, MR2, MR1, MR0), then ZQCL.
- Raises config_done, which gates all ACT/CAS/refresh traffic downstream.
- Each command is offered on a valid/ready handshake to the command arbiter.

Parameters:
- T_RESET, default 200: cycles mem_reset_n is held low after start.
- T_CKE, default 500: cycles from mem_reset_n release to CKE assertion.
- T_XPR, default 10: cycles from CKE assertion to first MRS valid.
- T_MRD, default 8: cycles from MRS acceptance to next MRS valid.
- T_MOD, default 24: cycles from MR0 acceptance to ZQCL valid.
- T_ZQINIT, default 1024: cycles from ZQCL acceptance to config_done.
- All timing parameters: legal range 1..65535. Wait counter is 16 bits.

Ports:
- clock  in  1  controller clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  single-cycle request to run the init sequence
- mr_table  in  98  MR values, 14 bits each; MRn at [14*n +: 14], n=0..6
- cmd_ready  in  1  downstream accepts the command this cycle
- mem_reset_n  out  1  DRAM RESET_n
- cke  out  1  DRAM CKE
- cmd_valid  out  1  command offered
- cmd_type  out  2  0=DES, 1=MRS, 2=ZQCL
- mr_sel  out  3  {BG0,BA1,BA0} = MR number
- mr_addr  out  14  A13:A0 payload
- busy  out  1  high in any state except IDLE/DONE
- config_done  out  1  initialization complete

Behaviour:
- Reset values: mem_reset_n=0, cke=0, cmd_valid=0, cmd_type=0, mr_sel=0, mr_addr=0, busy=0, config_done=0, state=IDLE, counter=0, mr index=0.
- Reset is asynchronous: asserting it at any point, mid-sequence included, forces all reset values immediately.
- States: IDLE, RST_HOLD, CKE_WAIT, XPR_WAIT, MRS_ISSUE, MRS_WAIT, MOD_WAIT, ZQ_ISSUE, ZQ_WAIT, DONE.
- IDLE: start sampled high at cycle S -> RST_HOLD at S+1, counter loaded.
- RST_HOLD: mem_reset_n=0 for exactly T_RESET cycles (S+1 .. S+T_RESET).
- CKE_WAIT: mem_reset_n=1 from S+T_RESET+1; cke stays 0 for T_CKE cycles.
- XPR_WAIT: cke=1 from S+T_RESET+T_CKE+1 and remains 1 until reset.
- MRS_ISSUE: first MRS valid T_XPR cycles after CKE rise.
  - Order of mr_sel: 3, 6, 5, 4, 2, 1, 0.
  - mr_addr = mr_table slice for mr_sel.
  - cmd_type=1.
- Handshake:
  - cmd_valid, cmd_type, mr_sel and mr_addr are held stable while cmd_valid=1 and cmd_ready=0.
  - Acceptance = cmd_valid & cmd_ready at a rising edge.
  - cmd_valid drops the cycle after acceptance; cmd_type returns to 0 (DES).
  - cmd_ready while cmd_valid=0 is ignored.
- Wait states (acceptance at cycle N in each case):
  - MRS_WAIT: next MRS cmd_valid at N+T_MRD.
  - After MR0 (7th MRS) -> MOD_WAIT; ZQCL valid at N+T_MOD, cmd_type=2, mr_sel=0, mr_addr bit 10=1, other bits 0.
  - After ZQCL -> ZQ_WAIT; config_done=1 at N+T_ZQINIT; state DONE.
- Sampling and ready stalls:
  - mr_table is sampled when each MRS first becomes valid.
  - mr_table changes while a command is stalled do not alter that command.
  - Ready stalls extend the sequence; wait counters never start before acceptance.
- DONE: config_done, cke and mem_reset_n stay 1.
  - start in DONE re-runs the full sequence: next cycle config_done=0, cke=0, mem_reset_n=0, state RST_HOLD.
- start while busy=1 is ignored.
- busy=1 from S+1 until the cycle config_done rises; then 0.

Test Plan:
- Reset then start pulse at cycle 10 (defaults) -> mem_reset_n rises at 211, cke rises at 711, first cmd_valid at 721 with cmd_type=1, mr_sel=3.
- cmd_ready tied 1, mr_table MRn = 14'h0100+n -> seven MRS in order 3,6,5,4,2,1,0 spaced 8 cycles with matching mr_addr; ZQCL (mr_addr=14'h0400) 24 cycles after MR0; config_done 1024 cycles after ZQCL.
- cmd_ready held 0 for 5 cycles on MR5 while mr_table changes -> outputs stable and unchanged; MR4 valid exactly T_MRD cycles after the late acceptance.
- start pulsed again during CKE_WAIT -> ignored, timing identical to the first scenario.
- reset asserted mid MRS_WAIT -> all outputs 0 asynchronously; a new start then runs the full sequence from RST_HOLD.
- start in DONE -> config_done falls next cycle, complete sequence repeats, config_done reasserts.
